uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a 16x oversampled front end and an on-chip receive FIFO. It is the receive-side counterpart of the system's UartTx path. Data width, parity mode, stop bits and FIFO depth are configurable. It serves both as a synthesizable peripheral and as the loop-back comm partner in system-level benches.

Parameters:
clk_freq, 50000000, system clock in Hz
uart_baud_rate, 9600, line baud rate
data_bits, 8, payload bits per frame (5..9)
parity_mode, 0, 0 none / 1 odd / 2 even
stop_bits, 1, stop bits checked (1 or 2)
fifo_addr_w, 4, FIFO depth = 2**fifo_addr_w entries

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rxd  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop request for the FIFO head
err_clr  in  1  clears the sticky error flags
rd_data  out  data_bits  FIFO head, first-word fall-through
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds 2**fifo_addr_w entries
count  out  fifo_addr_w+1  number of stored entries
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async): FSM=IDLE, sync FFs=1, FIFO pointers=0; empty=1, full=0, count=0, rd_data=0, all error flags=0.
- rxd passes through 2-FF synchroniser; the synchroniser output is the only rxd consumer.
- Tick divider: DIV = clk_freq/(uart_baud_rate*16), integer floor, min 1. One tick pulse per DIV clocks; counter free-runs, reloads to 0 on a start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: falling edge of the synchronised rxd -> START, tick count=0.
- START: sample on tick 7 (mid-bit). Sampled 1 -> false start, return to IDLE, no flags. Sampled 0 -> DATA.
- DATA: sample every 16 ticks, LSB first, data_bits samples. Then go to PARITY if parity_mode!=0, else STOP.
- PARITY: sample mid-bit. Odd: XOR(data,parity) must be 1. Even: it must be 0. A mismatch sets the parity_err flag; the byte is still pushed.
- STOP: sample stop_bits bits mid-bit.
  - All 1 -> push (or overrun) on the last stop-bit sample cycle, then IDLE. No wait for a full stop bit, so back-to-back frames are accepted.
  - Any 0 -> frame_err=1, byte discarded, go to BREAK.
- BREAK: wait until the synchronised rxd=1, then IDLE.
- Push latency: the byte is visible on rd_data, and empty falls, 1 clk after the final stop-bit sample.
- FIFO, first-word fall-through:
  - rd_data = mem[rd_ptr]; registered memory, registered pointers.
  - rd_en with empty=1 is ignored.
  - Push when full without a same-cycle pop: byte dropped, overrun=1, FIFO unchanged.
  - Push with a same-cycle pop: both are performed, count unchanged. This holds when full.
  - Pointers wrap modulo 2**fifo_addr_w; count uses an extra bit to distinguish full from empty.
- Error flags are sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
- Reset mid-frame: frame aborted, no push, no flags. After reset is released, the next falling edge starts a new frame.

Optional Feature:
UART_RX_TIMEOUT_EN
- Defined: adds output rx_timeout. It pulses 1 clk when the FIFO is non-empty, no start edge has been seen, and no pop has occurred for 4 character times.
  - Character time = (1+data_bits+(parity_mode!=0)+stop_bits)*16 ticks.
  - The idle counter restarts on any start edge or pop.
- Undefined: port absent, no counter logic.

Test Plan:
- All cases use clk_freq=50 MHz, baud 9600, so DIV=325 and 5200 clk/bit.
- Reset mid-frame: assert rst for 10 clk halfway through a 0x5A frame -> no push, empty=1, flags 0. A following 0x3C frame is received correctly.
- Single frame: send 0x55 (8N1) -> 1 clk after the stop sample, empty=0, count=1, rd_data=0x55. Pulse rd_en -> empty=1, count=0.
- Glitch: rxd low for 3 ticks (975 clk) -> false start, no push, no flags, FSM back in IDLE.
- Frame error: send 0xA5 with stop bit=0 -> frame_err=1, count=0. err_clr -> frame_err=0.
- Overrun: fifo_addr_w=2, send 0x01..0x05 with no reads -> full=1, count=4, overrun=1. Reads return 0x01,0x02,0x03,0x04, then empty=1.
- Parity: parity_mode=1, send 0x01 with parity bit 1 -> parity_err=1, rd_data=0x01. Send 0x03 with parity bit 1 -> no new error.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: FIFO read-side and status bundle of the UART receiver.
// master = consumer of received bytes, slave = the receiver itself.
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_fifo_if #(
  parameter int data_bits   = 8,
  parameter int fifo_addr_w = 4
);
  logic                   rd_en;
  logic                   err_clr;
  logic [data_bits-1:0]   rd_data;
  logic                   empty;
  logic                   full;
  logic [fifo_addr_w:0]   count;
  logic                   frame_err;
  logic                   parity_err;
  logic                   overrun;

  modport master (
    output rd_en, err_clr,
    input  rd_data, empty, full, count, frame_err, parity_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, empty, full, count, frame_err, parity_err, overrun
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver feeding a first-word fall-through FIFO.
// Optional macro UART_RX_TIMEOUT_EN adds the rx_timeout idle-pulse output.
`default_nettype none
`timescale 1ns/1ps

module uart_rx_fifo #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 9600,
  parameter int data_bits      = 8,
  parameter int parity_mode    = 0,
  parameter int stop_bits      = 1,
  parameter int fifo_addr_w    = 4
) (
  input  wire            clk,
  input  wire            rst,
  input  wire            rxd,
  uart_rx_fifo_if.slave  bus
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic           rx_timeout
`endif
);

  localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << fifo_addr_w;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  state_t                 state, state_nxt;
  logic                   sync1, rxd_s, rxd_prev;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick, start_edge, sample;
  logic [3:0]             tick_cnt, tick_nxt;
  logic [3:0]             bit_cnt, bit_nxt;
  logic [data_bits-1:0]   shift, shift_nxt;
  logic                   push, set_ferr, set_perr;

  logic [data_bits-1:0]   mem [DEPTH];
  logic [fifo_addr_w-1:0] wr_ptr, rd_ptr;
  logic [fifo_addr_w:0]   cnt;
  logic                   empty_w, full_w, do_pop, do_push, drop;
  logic                   ferr, perr, ovr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      rxd_s    <= sync1;
      rxd_prev <= rxd_s;
    end
  end

  assign start_edge = (state == ST_IDLE) && rxd_prev && !rxd_s;
  assign tick       = (div_cnt == DIV_W'(DIV - 1));
  // Start bit is judged at its middle (tick 7); every later bit 16 ticks apart.
  assign sample     = tick && ((state == ST_START) ? (tick_cnt == 4'd7) : (tick_cnt == 4'd15));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    div_cnt <= '0;
    else if (start_edge || tick) div_cnt <= '0;
    else                         div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick ? tick_cnt + 4'd1 : tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    push      = 1'b0;
    set_ferr  = 1'b0;
    set_perr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt = ST_START;
          tick_nxt  = '0;
        end
      end
      ST_START: begin
        if (sample) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_nxt = {rxd_s, shift[data_bits-1:1]};
          if (bit_cnt == 4'(data_bits - 1)) begin
            bit_nxt   = '0;
            state_nxt = (parity_mode != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          set_perr  = (^shift) ^ rxd_s ^ (parity_mode == 1);
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (!rxd_s) begin
            set_ferr  = 1'b1;
            state_nxt = ST_BREAK;
          end else if (bit_cnt == 4'(stop_bits - 1)) begin
            push      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign empty_w = (cnt == '0);
  assign full_w  = cnt[fifo_addr_w];
  assign do_pop  = bus.rd_en && !empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full_w || do_pop);
  assign drop    = push && full_w && !do_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + fifo_addr_w'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + fifo_addr_w'(1);
      if (do_push && !do_pop)      cnt <= cnt + (fifo_addr_w+1)'(1);
      else if (do_pop && !do_push) cnt <= cnt - (fifo_addr_w+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr <= 1'b0;
      perr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (set_ferr)         ferr <= 1'b1;
      else if (bus.err_clr) ferr <= 1'b0;
      if (set_perr)         perr <= 1'b1;
      else if (bus.err_clr) perr <= 1'b0;
      if (drop)             ovr  <= 1'b1;
      else if (bus.err_clr) ovr  <= 1'b0;
    end
  end

  assign bus.rd_data    = mem[rd_ptr];
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.count      = cnt;
  assign bus.frame_err  = ferr;
  assign bus.parity_err = perr;
  assign bus.overrun    = ovr;

`ifdef UART_RX_TIMEOUT_EN
  localparam int CHAR_TICKS = (1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits) * 16;
  localparam int TO_TICKS   = 4 * CHAR_TICKS;
  localparam int TO_W       = $clog2(TO_TICKS + 1);

  logic [TO_W-1:0] idle_cnt;

  // Saturates at the limit so one idle stretch yields exactly one pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= 1'b0;
      if (empty_w || start_edge || do_pop) begin
        idle_cnt <= '0;
      end else if (tick && (idle_cnt != TO_W'(TO_TICKS))) begin
        idle_cnt <= idle_cnt + TO_W'(1);
        if (idle_cnt == TO_W'(TO_TICKS - 1)) rx_timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
